// File: rtl/sens_ultra_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sens_ultra_pkg
//  Description : Shared types and constants for the SensUltra measurement
//                sequencer (FSM state encoding, counter widths, timeout code).
//  Revision    : 1.0 - initial release
// ============================================================================
package sens_ultra_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    // Width of the wrapping completed-measurement counter
    localparam int MEAS_COUNT_W = 16;

    // Result code reported on timeout: all ones across the result width
    function automatic logic [63:0] timeout_code(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sens_ultra_echo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sens_ultra_echo_sync
//  Description : Two-flop synchronizer for the raw echo pin. When the macro
//                SENS_ULTRA_GLITCH_FILTER_EN is defined, a stability filter
//                follows: the output only changes after three consecutive
//                equal synchronized samples (both edges delayed 3 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module sens_ultra_echo_sync
    import sens_ultra_pkg::*;
(
    input  logic ACLK,
    input  logic ARESETN,
    input  logic echo_in,
    output logic echo_s
);

    logic r_sync1;
    logic r_sync2;

    // Metastability guard for the asynchronous echo pin
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= echo_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SENS_ULTRA_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // Follow the synchronized echo only once it has been stable for 3 samples
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_hist <= 2'b00;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            if ((r_sync2 == r_hist[0]) && (r_sync2 == r_hist[1])) begin
                r_filt <= r_sync2;
            end
        end
    end

    assign echo_s = r_filt;
`else
    assign echo_s = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/sens_ultra_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sens_ultra_ctrl
//  Description : SensUltra ultrasonic ranging sequencer. Fires the trigger
//                pulse, times the echo width, handles echo timeout and
//                schedules single-shot or periodic measurements.
//                Optional macro SENS_ULTRA_GLITCH_FILTER_EN enables the echo
//                stability filter inside sens_ultra_echo_sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module sens_ultra_ctrl
    import sens_ultra_pkg::*;
#(
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int CNT_W          = 24,
    parameter int PERIOD_W       = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cfg_enable,
    input  logic                    cfg_continuous,
    input  logic [PERIOD_W-1:0]     cfg_period,
    input  logic                    start,
    input  logic                    echo_in,
    output logic                    trig_out,
    output logic                    busy,
    output logic [CNT_W-1:0]        meas_data,
    output logic                    meas_valid,
    output logic                    timeout,
    output logic [MEAS_COUNT_W-1:0] meas_count
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TRIG_W-1:0] c_trig_last = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_tmo_code  = CNT_W'(timeout_code(CNT_W));

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_echo_s;
    logic                      w_meas_done;
    logic                      w_tmo_hit;
    logic                      w_trig_entry;
    logic                      w_period_hit;
    logic [PERIOD_W:0]         w_period_next;

    logic [TRIG_W-1:0]         r_trig_cnt;
    logic [TMO_W-1:0]          r_tmo;
    logic [CNT_W-1:0]          r_width;
    logic [PERIOD_W-1:0]       r_period_cnt;

    logic                      r_trig;
    logic                      r_busy;
    logic [CNT_W-1:0]          r_meas_data;
    logic                      r_meas_valid;
    logic                      r_timeout;
    logic [MEAS_COUNT_W-1:0]   r_meas_count;

    sens_ultra_echo_sync u_echo_sync (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .echo_in (echo_in),
        .echo_s  (w_echo_s)
    );

    // Period elapsed once (cycles since trigger rise + 1) >= cfg_period; the
    // widened add keeps cfg_period = 0 meaning "immediately"
    assign w_period_next = {1'b0, r_period_cnt} + {{PERIOD_W{1'b0}}, 1'b1};
    assign w_period_hit  = (w_period_next >= {1'b0, cfg_period});
    assign w_trig_entry  = (w_next == TRIG) && (r_state != TRIG);

    // Next-state decode and measurement-completion events
    always_comb begin
        w_next      = r_state;
        w_meas_done = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_continuous || start) w_next = TRIG;
            end
            TRIG: begin
                if (r_trig_cnt == c_trig_last) w_next = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (r_tmo == c_tmo_last) begin
                    w_tmo_hit = 1'b1;
                    w_next    = HOLDOFF;
                end else if (w_echo_s) begin
                    w_next = MEASURE;
                end
            end
            MEASURE: begin
                if (r_tmo == c_tmo_last) begin
                    w_tmo_hit = 1'b1;
                    w_next    = HOLDOFF;
                end else if (!w_echo_s) begin
                    w_meas_done = 1'b1;
                    w_next      = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!cfg_continuous)   w_next = IDLE;
                else if (w_period_hit) w_next = TRIG;
            end
            default: w_next = IDLE;
        endcase
        // Disabling aborts from any state without reporting a result
        if (!cfg_enable) begin
            w_next      = IDLE;
            w_meas_done = 1'b0;
            w_tmo_hit   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Trigger pin and busy are registered from the next state so they never glitch
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_trig <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_trig <= (w_next == TRIG);
            r_busy <= (w_next != IDLE);
        end
    end

    // Trigger width, elapsed-time, echo-width and period counters
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_trig_cnt   <= '0;
            r_tmo        <= '0;
            r_width      <= '0;
            r_period_cnt <= '0;
        end else begin
            if (r_state == TRIG) r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
            else                 r_trig_cnt <= '0;

            if ((r_state == WAIT_ECHO) || (r_state == MEASURE)) r_tmo <= r_tmo + TMO_W'(1);
            else                                                 r_tmo <= '0;

            // The sample that moves WAIT_ECHO to MEASURE already counts as 1
            if (r_state == WAIT_ECHO) begin
                r_width <= CNT_W'(1);
            end else if ((r_state == MEASURE) && w_echo_s && (r_width != {CNT_W{1'b1}})) begin
                r_width <= r_width + CNT_W'(1);
            end

            if (w_trig_entry) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt != {PERIOD_W{1'b1}}) begin
                r_period_cnt <= r_period_cnt + PERIOD_W'(1);
            end
        end
    end

    // Result, event pulse, sticky timeout flag and completion counter
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_meas_data  <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_meas_count <= '0;
        end else begin
            r_meas_valid <= w_meas_done || w_tmo_hit;
            if ((r_state == IDLE) && start)        r_timeout <= 1'b0;
            if (w_trig_entry && cfg_continuous)    r_timeout <= 1'b0;
            if (w_meas_done) begin
                r_meas_data  <= r_width;
                r_meas_count <= r_meas_count + MEAS_COUNT_W'(1);
            end
            if (w_tmo_hit) begin
                r_meas_data <= c_tmo_code;
                r_timeout   <= 1'b1;
            end
        end
    end

    assign trig_out   = r_trig;
    assign busy       = r_busy;
    assign meas_data  = r_meas_data;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;
    assign meas_count = r_meas_count;

endmodule
`default_nettype wire

// File: tb/tb_sens_ultra_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sens_ultra_ctrl
//  Description : Self-checking bench for sens_ultra_ctrl with randomized echo
//                timing checked against expectations derived from the
//                measurement rules (width in cycles, fixed latencies).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sens_ultra_ctrl;

    localparam int TRIG_CYCLES    = 10;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int CNT_W          = 24;
    localparam int PERIOD_W       = 32;
`ifdef SENS_ULTRA_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic                ACLK           = 1'b0;
    logic                ARESETN        = 1'b0;
    logic                cfg_enable     = 1'b0;
    logic                cfg_continuous = 1'b0;
    logic [PERIOD_W-1:0] cfg_period     = '0;
    logic                start          = 1'b0;
    logic                echo_in        = 1'b0;
    logic                trig_out;
    logic                busy;
    logic [CNT_W-1:0]    meas_data;
    logic                meas_valid;
    logic                timeout;
    logic [15:0]         meas_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int               exp_count = 0;
    logic [CNT_W-1:0] exp_data  = '0;
    logic             exp_tmo   = 1'b0;

    // Record of every meas_valid pulse
    int               v_cyc[$];
    logic [CNT_W-1:0] v_data[$];

    sens_ultra_ctrl #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W),
        .PERIOD_W       (PERIOD_W)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .cfg_enable     (cfg_enable),
        .cfg_continuous (cfg_continuous),
        .cfg_period     (cfg_period),
        .start          (start),
        .echo_in        (echo_in),
        .trig_out       (trig_out),
        .busy           (busy),
        .meas_data      (meas_data),
        .meas_valid     (meas_valid),
        .timeout        (timeout),
        .meas_count     (meas_count)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc++;

    always @(negedge ACLK) begin
        if (meas_valid) begin
            v_cyc.push_back(cyc);
            v_data.push_back(meas_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // One single-shot measurement; echo starts dly cycles after the trigger
    // falls and lasts wid cycles (no echo when want_tmo is set)
    task automatic run_single(input int dly, input int wid, input bit poke, input bit want_tmo);
        int len;
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_tmo = 1'b0;
        check_val("tmo_clear", timeout, exp_tmo);
        check_val("trig_rise", trig_out, 1);
        len = 0;
        while (trig_out && len < 100) begin
            len++;
            if (poke) start = (len == 4);
            step();
        end
        start = 1'b0;
        check_val("trig_len", len, TRIG_CYCLES);
        n = 0;
        if (!want_tmo) begin
            repeat (dly) step();
            echo_in = 1'b1;
            repeat (wid) step();
            echo_in = 1'b0;
            if (poke) begin
                start = 1'b1;
                step();
                start = 1'b0;
                n = 1;
            end
        end
        while (!meas_valid && n < 400) begin
            step();
            n++;
        end
        if (want_tmo) begin
            exp_data = {CNT_W{1'b1}};
            exp_tmo  = 1'b1;
            check_val("tmo_lat", n, TIMEOUT_CYCLES);
        end else begin
            exp_data = CNT_W'(wid);
            exp_count++;
            check_val("valid_lat", n, LAT);
        end
        check_val("data", meas_data, exp_data);
        check_val("count", meas_count, exp_count);
        check_val("tmo_flag", timeout, exp_tmo);
        check_val("busy_holdoff", busy, 1);
        step();
        check_val("valid_pulse", meas_valid, 0);
        check_val("busy_fall", busy, 0);
    endtask

    // Periodic measurements: trigger rises must be exactly per cycles apart
    task automatic run_periodic(input int per, input int nmeas, input int wmin, input int wmax);
        int rise_prev;
        int n;
        int dly;
        int wid;
        cfg_period     = PERIOD_W'(per);
        cfg_continuous = 1'b1;
        rise_prev      = -1;
        for (int i = 0; i < nmeas; i++) begin
            n = 0;
            while (!trig_out && n < 2000) begin
                step();
                n++;
            end
            if (rise_prev >= 0) check_val("period", cyc - rise_prev, per);
            rise_prev = cyc;
            n = 0;
            while (trig_out && n < 100) begin
                step();
                n++;
            end
            check_val("ptrig_len", n, TRIG_CYCLES);
            dly = $urandom_range(0, 20);
            wid = $urandom_range(wmin, wmax);
            repeat (dly) step();
            echo_in = 1'b1;
            repeat (wid) step();
            echo_in = 1'b0;
            n = 0;
            while (!meas_valid && n < 400) begin
                step();
                n++;
            end
            check_val("plat", n, LAT);
            exp_count++;
            exp_data = CNT_W'(wid);
            check_val("pdata", meas_data, exp_data);
            check_val("pcount", meas_count, exp_count);
            if (i == nmeas - 1) cfg_continuous = 1'b0;
        end
        step();
        check_val("pbusy_fall", busy, 0);
    endtask

    initial begin
        int n;
        int qsz;
        int t_spike;
        int t_pulse;

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_trig", trig_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_data", meas_data, 0);
        check_val("rst_valid", meas_valid, 0);
        check_val("rst_tmo", timeout, 0);
        check_val("rst_count", meas_count, 0);
        ARESETN = 1'b1;
        step();
        cfg_enable = 1'b1;
        step();

        // Directed single shot, then randomized single shots
        run_single(20, 50, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_single($urandom_range(0, 40), $urandom_range(3, 100), 1'b0, 1'b0);
        end

        // Timeout, then a normal measurement whose start clears the flag
        run_single(0, 0, 1'b0, 1'b1);
        run_single($urandom_range(0, 40), $urandom_range(3, 100), 1'b0, 1'b0);

        // start pulses while busy are ignored
        run_single($urandom_range(0, 40), $urandom_range(3, 100), 1'b1, 1'b0);

        // Periodic mode
        run_periodic(300, 4, 40, 40);
        run_periodic($urandom_range(120, 250), 3, 3, 60);

        // Abort mid-MEASURE by dropping enable
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (trig_out && n < 100) begin
            step();
            n++;
        end
        echo_in = 1'b1;
        repeat (12) step();
        qsz = v_cyc.size();
        cfg_enable = 1'b0;
        step();
        check_val("abort_busy", busy, 0);
        check_val("abort_trig", trig_out, 0);
        echo_in = 1'b0;
        repeat (10) step();
        check_val("abort_novalid", v_cyc.size(), qsz);
        check_val("abort_data", meas_data, exp_data);
        check_val("abort_count", meas_count, exp_count);
        cfg_enable = 1'b1;
        step();

        // Short spike followed by a clean 30-cycle echo
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (trig_out && n < 100) begin
            step();
            n++;
        end
        repeat (5) step();
        v_cyc.delete();
        v_data.delete();
        echo_in = 1'b1;
        repeat (2) step();
        echo_in = 1'b0;
        t_spike = cyc;
        repeat (6) step();
        echo_in = 1'b1;
        repeat (30) step();
        echo_in = 1'b0;
        t_pulse = cyc;
        repeat (15) step();
        check_val("glitch_nvalid", v_cyc.size(), 1);
        exp_count++;
`ifdef SENS_ULTRA_GLITCH_FILTER_EN
        exp_data = CNT_W'(30);
        if (v_cyc.size() > 0) begin
            check_val("glitch_data", v_data[0], exp_data);
            check_val("glitch_lat", v_cyc[0] - t_pulse, 6);
        end
`else
        exp_data = CNT_W'(2);
        if (v_cyc.size() > 0) begin
            check_val("glitch_data", v_data[0], exp_data);
            check_val("glitch_lat", v_cyc[0] - t_spike, 3);
        end
`endif
        check_val("glitch_count", meas_count, exp_count);

        // Asynchronous reset in the middle of the trigger pulse
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check_val("pre_rst_trig", trig_out, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        exp_count = 0;
        exp_data  = '0;
        exp_tmo   = 1'b0;
        check_val("arst_trig", trig_out, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_count", meas_count, exp_count);
        check_val("arst_data", meas_data, exp_data);
        check_val("arst_tmo", timeout, exp_tmo);
        repeat (3) step();
        ARESETN = 1'b1;
        repeat (3) step();
        check_val("post_rst_busy", busy, 0);
        run_single($urandom_range(0, 40), $urandom_range(3, 100), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
